// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for the digit-serial subtractor.
// The master launches an operation and the slave returns the result.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Y;
  logic             Bout;

  modport master (
    output start, A, B, Bin,
    input  busy, done, Y, Bout
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, Y, Bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: Y = A - B - Bin, one 2-bit digit per clock, LSB first.
// Y/Bout only change on completion, so intermediate digits are never visible.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int N     = WIDTH / 2;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       dig;
  logic [WIDTH+1:0] res_cat;

  // {borrow, digit} of a 2-bit subtraction, as a 3-bit two's complement value
  function automatic logic [2:0] digit_sub(input logic [1:0] a,
                                           input logic [1:0] b,
                                           input logic       bi);
    logic signed [2:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b}) - $signed({2'b00, bi});
    return $unsigned(diff);
  endfunction

  assign dig     = digit_sub(a_sh[1:0], b_sh[1:0], brw);
  // New digit enters at the top; after N digits the LSB digit sits at bit 0
  assign res_cat = {dig[1:0], res};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      brw      <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.Y    <= '0;
      bus.Bout <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh     <= bus.A;
            b_sh     <= bus.B;
            brw      <= bus.Bin;
            res      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 2;
          b_sh <= b_sh >> 2;
          brw  <= dig[2];
          res  <= res_cat[WIDTH+1:2];
          if (cnt == LAST) begin
            bus.Y    <= res_cat[WIDTH+1:2];
            bus.Bout <= dig[2];
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed table and sequences at WIDTH=4,
// randomized back-to-back traffic at WIDTH=8 against an arithmetic model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(4)) if4 ();
  serial_subtractor_if #(.WIDTH(8)) if8 ();

  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] y;
    logic       bout;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] prev_y;
  logic       prev_bout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=4 operation: accept at edge 0, result at edge 2, done for one cycle
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                      input logic [3:0] ey, input logic eb);
    if4.A = a; if4.B = b; if4.Bin = bin; if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    if4.A = ~a; if4.B = ~b; if4.Bin = ~bin;
    chk("busy_e0", 32'(if4.busy), 32'd1);
    chk("done_e0", 32'(if4.done), 32'd0);
    tick();
    chk("busy_e1", 32'(if4.busy), 32'd1);
    chk("done_e1", 32'(if4.done), 32'd0);
    chk("y_hold_e1", 32'(if4.Y), 32'(prev_y));
    chk("bout_hold_e1", 32'(if4.Bout), 32'(prev_bout));
    tick();
    chk("done_e2", 32'(if4.done), 32'd1);
    chk("busy_e2", 32'(if4.busy), 32'd0);
    chk("y", 32'(if4.Y), 32'(ey));
    chk("bout", 32'(if4.Bout), 32'(eb));
    tick();
    chk("done_pulse", 32'(if4.done), 32'd0);
    chk("y_keep", 32'(if4.Y), 32'(ey));
    prev_y = ey;
    prev_bout = eb;
  endtask

  initial begin
    logic [8:0] exp9;
    logic [8:0] pend;
    int         left;
    bit         idle;
    int         ops;
    int         cyc;
    logic [7:0] ra, rb;
    logic       rbin;

    rst_n = 1'b0;
    if4.start = 1'b0; if4.A = '0; if4.B = '0; if4.Bin = 1'b0;
    if8.start = 1'b0; if8.A = '0; if8.B = '0; if8.Bin = 1'b0;
    prev_y = '0; prev_bout = 1'b0;

    vecs.push_back('{4'h9, 4'h3, 1'b0, 4'h6, 1'b0});
    vecs.push_back('{4'h3, 4'h9, 1'b0, 4'hA, 1'b1});
    vecs.push_back('{4'h0, 4'h0, 1'b1, 4'hF, 1'b1});
    vecs.push_back('{4'hF, 4'hF, 1'b1, 4'hF, 1'b1});
    vecs.push_back('{4'h5, 4'h2, 1'b0, 4'h3, 1'b0});
    vecs.push_back('{4'hF, 4'h0, 1'b0, 4'hF, 1'b0});
    vecs.push_back('{4'h0, 4'hF, 1'b0, 4'h1, 1'b1});
    vecs.push_back('{4'h7, 4'h7, 1'b0, 4'h0, 1'b0});
    vecs.push_back('{4'hC, 4'h3, 1'b1, 4'h8, 1'b0});

    tick();
    tick();
    chk("rst_busy", 32'(if4.busy), 32'd0);
    chk("rst_done", 32'(if4.done), 32'd0);
    chk("rst_y", 32'(if4.Y), 32'd0);
    chk("rst_bout", 32'(if4.Bout), 32'd0);
    chk("rst_busy8", 32'(if8.busy), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++)
      run4(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].y, vecs[i].bout);

    // Start while busy is ignored and never queued
    if4.A = 4'h8; if4.B = 4'h1; if4.Bin = 1'b0; if4.start = 1'b1;
    tick();
    if4.A = 4'h2; if4.B = 4'h2;
    tick();
    if4.start = 1'b0;
    chk("ign_busy_e1", 32'(if4.busy), 32'd1);
    tick();
    chk("ign_done", 32'(if4.done), 32'd1);
    chk("ign_y", 32'(if4.Y), 32'h7);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ign_no_done", 32'(if4.done), 32'd0);
      chk("ign_busy", 32'(if4.busy), 32'd0);
      chk("ign_y_hold", 32'(if4.Y), 32'h7);
    end
    prev_y = 4'h7; prev_bout = 1'b0;

    // Asynchronous reset mid-run aborts without a done pulse
    if4.A = 4'hC; if4.B = 4'h4; if4.Bin = 1'b0; if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(if4.busy), 32'd0);
    chk("arst_done", 32'(if4.done), 32'd0);
    chk("arst_y", 32'(if4.Y), 32'd0);
    chk("arst_bout", 32'(if4.Bout), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_no_done", 32'(if4.done), 32'd0);
      chk("arst_idle", 32'(if4.busy), 32'd0);
    end
    prev_y = '0; prev_bout = 1'b0;
    run4(4'h5, 4'h2, 1'b0, 4'h3, 1'b0);

    // WIDTH=8, start held high: accept whenever idle, done 4 edges later
    idle = 1'b1; left = 0; ops = 0; cyc = 0; pend = '0;
    ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
    if8.A = ra; if8.B = rb; if8.Bin = rbin; if8.start = 1'b1;
    while (ops < 1000 && cyc < 6000) begin
      tick();
      cyc++;
      if (idle) begin
        pend = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
        idle = 1'b0;
        left = 4;
        chk("r_busy", 32'(if8.busy), 32'd1);
        chk("r_done", 32'(if8.done), 32'd0);
      end else begin
        left--;
        if (left == 0) begin
          idle = 1'b1;
          ops++;
          exp9 = pend;
          chk("r_done", 32'(if8.done), 32'd1);
          chk("r_result", 32'({if8.Bout, if8.Y}), 32'(exp9));
        end else begin
          chk("r_done", 32'(if8.done), 32'd0);
        end
      end
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      if8.A = ra; if8.B = rb; if8.Bin = rbin;
    end
    chk("r_ops_completed", 32'(ops), 32'd1000);
    if8.start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
